// File: rtl/fir_mac_core.sv
// Sequential FIR multiply-accumulate core. It stores one sample per handshake in a
// circular buffer, then spends TAPS cycles accumulating c[k]*x[n-k].
module fir_mac_core #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int ACC_WIDTH  = 38
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         input_valid,
  input  logic signed [DATA_WIDTH-1:0] input_data,
  output logic                         input_ready,
  output logic        [ADDR_WIDTH-1:0] coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_data,
  output logic                         output_valid,
  output logic signed [ACC_WIDTH-1:0]  output_data
);

  localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;

  // state | meaning
  // IDLE  | waiting for a sample; input_ready high, coef_addr 0
  // MAC   | accumulating tap k of the current output, one tap per cycle
  typedef enum logic {IDLE, MAC} state_t;

  state_t                        state;
  logic signed [DATA_WIDTH-1:0]  sbuf [TAPS];
  logic        [ADDR_WIDTH-1:0]  wr_ptr;
  logic        [ADDR_WIDTH-1:0]  k;
  logic        [ADDR_WIDTH-1:0]  rd_idx;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [ACC_WIDTH-1:0]   acc_next;
  logic signed [PROD_WIDTH-1:0]  prod;
  logic signed [ACC_WIDTH-1:0]   prod_ext;

  // Newest sample sits at wr_ptr, so x[n-k] is k slots behind it; wraps in ADDR_WIDTH bits.
  assign rd_idx   = wr_ptr - k;
  assign prod     = sbuf[rd_idx] * coef_data;
  assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
  assign acc_next = acc + prod_ext;

  assign input_ready = (state == IDLE);
  assign coef_addr   = (state == MAC) ? k : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      k            <= '0;
      wr_ptr       <= '0;
      acc          <= '0;
      output_valid <= 1'b0;
      output_data  <= '0;
      for (int i = 0; i < TAPS; i++) begin
        sbuf[i] <= '0;
      end
    end else begin
      output_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (input_valid) begin
            sbuf[wr_ptr] <= input_data;
            acc          <= '0;
            k            <= '0;
            state        <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          k   <= k + ADDR_WIDTH'(1);
          if (k == ADDR_WIDTH'(TAPS - 1)) begin
            output_data  <= acc_next;
            output_valid <= 1'b1;
            wr_ptr       <= wr_ptr + ADDR_WIDTH'(1);
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fir_mac_core.md
Name: fir_mac_core

Overview:
Sequential multiply-accumulate core for the FIR filter datapath. It accepts one input sample per handshake and stores it in a circular sample buffer. It then computes y[n] = sum over k of c[k]*x[n-k] across TAPS cycles, reading coefficients from an external coefficient ROM. The 38-bit result feeds the downstream output register stage.

Parameters:
DATA_WIDTH, 16, signed sample width
COEF_WIDTH, 16, signed coefficient width
TAPS, 64, filter length; power of two, at least 2
ADDR_WIDTH, 6, log2(TAPS); width of the tap index and buffer pointer
ACC_WIDTH, 38, accumulator/result width; must be at least DATA_WIDTH+COEF_WIDTH+ADDR_WIDTH

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
input_valid  input  1  input_data is valid this cycle
input_data  input  DATA_WIDTH  signed input sample
input_ready  output  1  core can accept a sample this cycle
coef_addr  output  ADDR_WIDTH  coefficient ROM address (tap index k)
coef_data  input  COEF_WIDTH  signed coefficient; combinational ROM read of coef_addr, same cycle
output_valid  output  1  one-cycle pulse: output_data holds a new result
output_data  output  ACC_WIDTH  signed filter result; held until the next result

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, k=0, wr_ptr=0, acc=0, all TAPS buffer entries=0, output_valid=0, output_data=0. input_ready=1 in the cycle after reset. rst overrides all other inputs.
- FSM states are IDLE and MAC.
- IDLE:
  - input_ready=1, coef_addr=0.
  - Edge with input_valid=1 (accept edge E0): buf[wr_ptr] <= input_data, acc <= 0, k <= 0, state <= MAC.
  - input_valid=0: no change.
- MAC:
  - input_ready=0; input_valid is ignored and the sample is not consumed. The producer holds it.
  - coef_addr=k. Sample index = (wr_ptr - k) mod TAPS, wrapping naturally in ADDR_WIDTH bits.
  - Each edge: acc <= acc + sext(buf[idx] * coef_data); k <= k+1.
- Last MAC edge (k=TAPS-1), at edge E0+TAPS:
  - output_data <= final sum (acc + last product), output_valid <= 1.
  - wr_ptr <= wr_ptr+1 (mod TAPS), state <= IDLE.
- output_valid is 1 for exactly one cycle, the cycle after E0+TAPS, and input_ready is 1 in that same cycle.
- Latency is TAPS edges from accept to output_valid. Throughput is at most one sample per TAPS+1 cycles.
- Arithmetic:
  - Two's complement throughout.
  - Product is a full DATA_WIDTH+COEF_WIDTH signed value, sign-extended to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH, with no saturation. With the defaults, overflow is impossible.
- Buffer history:
  - Samples not yet written are read as 0, so the first TAPS outputs reflect zero initial history.
  - wr_ptr wraps from TAPS-1 to 0 and the oldest sample is overwritten.
- Reset mid-MAC: the computation is aborted, no output_valid is produced, the buffer is cleared and the core returns to IDLE.
- input_valid is sampled only in IDLE and needs no handshake hold beyond the accept edge.

Test Plan:
1. Impulse response:
   - Stimulus: coef[k]=k+1; after reset, feed 1 then 69 zeros.
   - Required: outputs 1,2,...,64, then 0,0,0,0,0,0.
   - Checks buffer indexing and wr_ptr wrap.
2. Step response:
   - Stimulus: all coef=1; feed input 1 seventy times.
   - Required: outputs ramp 1..64, then remain at 64.
3. Signed extreme:
   - Stimulus: all coef=-32768; feed -32768 sixty-four times.
   - Required: 64th output = 68719476736 (2^36), with correct sign through the ACC_WIDTH extension.
   - Also: feed 32767 with coef=-32768, single tap nonzero. Required: -1073709056.
4. Handshake/latency:
   - Stimulus: hold input_valid=1 continuously.
   - Required: input_ready high for exactly 1 cycle in every 65; output_valid pulses 64 edges after each accept edge; samples are accepted only when input_ready=1.
5. Reset mid-operation:
   - Stimulus: assert rst at k=30 of a MAC with nonzero history.
   - Required: no output_valid, output_data=0, input_ready=1 next cycle; a subsequent impulse reproduces scenario 1 exactly.
6. Output hold:
   - Stimulus: after one result, keep input_valid=0 for 200 cycles.
   - Required: output_data is unchanged, output_valid stays 0, coef_addr=0.
